ldpc_codeword_assembler: RTL and testbench
==========================================

LDPC_CODEWORD_ASSEMBLER -- requirements
Module: ldpc_codeword_assembler

Interface
REQ-001 Parameter: width, default 8, bits per beat on every stream; legal values 8 and 16 only.
REQ-002 Parameter: INFO_BITS, default 7136, info bits per codeword.
REQ-003 Parameter: PAR_BITS, default 1024, check bits per codeword, i.e. 1022 parity plus 2 fill bits.
REQ-004 Port: clk  input  1  the single clock; all logic on its rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port: s_info_tdata  input  width  systematic info beat, MSB = earliest bit.
REQ-007 Port: s_info_tvalid  input  1  info beat valid.
REQ-008 Port: s_info_tready  output  1  info beat accepted when tvalid and tready are both high.
REQ-009 Port: s_par_tdata  input  width  check-bit beat from the LDPC encoder, MSB first.
REQ-010 Port: s_par_tvalid  input  1  check beat valid.
REQ-011 Port: s_par_tlast  input  1  encoder's end-of-check-block marker.
REQ-012 Port: s_par_tready  output  1  check beat accepted.
REQ-013 Port: m_axis_tdata  output  width  codeword beat.
REQ-014 Port: m_axis_tvalid  output  1  codeword beat valid.
REQ-015 Port: m_axis_tlast  output  1  high on the final beat of each 8160-bit codeword.
REQ-016 Port: m_axis_tready  input  1  downstream accept.
REQ-017 Port: frame_err  output  1  one-cycle pulse on a check-stream tlast misalignment.

Function
REQ-018 The block SHALL emit each codeword as INFO_BITS/width info beats, then PAR_BITS/width check beats; defaults give 892+128 beats at width=8 and 446+64 at width=16.
REQ-019 FSM states: S_INFO and S_PAR.
REQ-020 S_INFO: accept only info beats; s_par_tready=0.
REQ-021 S_PAR: accept only check beats; s_info_tready=0.
REQ-022 S_INFO to S_PAR transition SHALL occur on acceptance of info beat INFO_BITS/width-1.
REQ-023 S_PAR to S_INFO transition SHALL occur on acceptance of check beat PAR_BITS/width-1.
REQ-024 Beat counter: increments by 1 per accepted beat in the active state; clears to 0 on every state transition.
REQ-025 Output path: registered, with a 2-entry skid buffer.
REQ-026 Latency: an accepted input beat SHALL appear on m_axis with m_axis_tvalid=1 no earlier than the next cycle.
REQ-027 Throughput: with m_axis_tready held high, sustained throughput SHALL be 1 beat/cycle, including across both state boundaries.
REQ-028 The input tready of the active state SHALL be high iff the skid buffer holds at most one entry.
REQ-029 Tready SHALL depend only on registered state, never combinationally on m_axis_tready or any tvalid.
REQ-030 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable.
REQ-031 Data SHALL pass bit-exact; no reordering within or across beats.
REQ-032 m_axis_tlast SHALL be 1 only on the beat sourced from check beat PAR_BITS/width-1.
REQ-033 Framing SHALL use the beat counter only; s_par_tlast does not alter framing.
REQ-034 frame_err SHALL pulse high for one cycle after any accepted check beat where s_par_tlast differs from (counter==PAR_BITS/width-1).
REQ-035 A simultaneous m_axis output transfer and input acceptance in the same cycle SHALL keep the buffer occupancy unchanged.
REQ-036 Valid inputs presented to the inactive stream SHALL be ignored and left pending, never dropped.
REQ-037 Back-to-back codewords SHALL need no idle cycle between them.

Reset
REQ-038 While rst_n=0 at a clk edge, the block SHALL set state=S_INFO, counter=0, and empty the skid buffer.
REQ-039 The same reset SHALL drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_info_tready=0, s_par_tready=0 and frame_err=0.
REQ-040 A reset mid-codeword SHALL discard the partial codeword; the next codeword starts at info beat 0.
REQ-041 s_info_tready SHALL rise in the first cycle after rst_n returns high.

Verification
REQ-042 width=8, info bytes 0x00..0x7B repeating, check bytes 0xA5^idx, tready=1 -> 1020 beats, bit-exact; tlast only on beat 1019; 1020 cycles from first to last output.
REQ-043 Random m_axis_tready (50%) and random input tvalid over 3 back-to-back codewords -> no loss, duplication or reorder; tdata/tlast stable while stalled; tlast at beats 1019, 2039, 3059.
REQ-044 s_par_tlast asserted on check beat 100 and not on 127 -> frame_err pulses twice; framing unchanged; m_axis_tlast still on beat 1019.
REQ-045 Check beats offered during S_INFO -> s_par_tready=0 until info beat 891 is accepted; no check data appears on m_axis before info beat 891 is output.
REQ-046 rst_n=0 for one cycle after info beat 500 -> all outputs 0 next cycle; the following full codeword is emitted correctly with tlast at its beat 1019.
REQ-047 width=16 -> 510 beats per codeword with tlast on beat 509 and 446/64 split; all other checks per REQ-042.

Source files
------------

// File: rtl/ldpc_codeword_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_codeword_assembler
//  Description : Merges a systematic info stream and an LDPC check-bit stream
//                into one codeword stream. Each codeword is the info beats
//                followed by the check beats. The output is registered and
//                backed by a 2-entry skid buffer. Both input readys are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldpc_codeword_assembler #(
    parameter int WIDTH     = 8,     // bits per beat, 8 or 16
    parameter int INFO_BITS = 7136,  // info bits per codeword
    parameter int PAR_BITS  = 1024   // 1022 parity bits plus 2 fill bits
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_info_tdata,
    input  logic             s_info_tvalid,
    output logic             s_info_tready,
    input  logic [WIDTH-1:0] s_par_tdata,
    input  logic             s_par_tvalid,
    input  logic             s_par_tlast,
    output logic             s_par_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             frame_err
);

    localparam int c_INFO_BEATS = INFO_BITS / WIDTH;
    localparam int c_PAR_BEATS  = PAR_BITS / WIDTH;
    localparam int c_MAX_BEATS  = (c_INFO_BEATS > c_PAR_BEATS) ? c_INFO_BEATS : c_PAR_BEATS;
    localparam int c_CNT_W      = $clog2(c_MAX_BEATS);

    localparam logic [c_CNT_W-1:0] c_INFO_LAST = c_CNT_W'(c_INFO_BEATS - 1);
    localparam logic [c_CNT_W-1:0] c_PAR_LAST  = c_CNT_W'(c_PAR_BEATS - 1);

    localparam logic [0:0] S_INFO = 1'b0;
    localparam logic [0:0] S_PAR  = 1'b1;

    // Framing state
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_info_ready;
    logic               r_par_ready;

    // Skid buffer: the head entry drives m_axis directly, the skid entry is
    // the second slot that absorbs a beat accepted while the head is stalled.
    logic [1:0]         r_occ;
    logic [WIDTH-1:0]   r_head_data;
    logic               r_head_last;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_skid_last;
    logic               r_m_valid;
    logic               r_frame_err;

    logic               w_info_acc;
    logic               w_par_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_cnt_last;
    logic               w_par_cnt_last;
    logic [WIDTH-1:0]   w_in_data;
    logic               w_in_last;
    logic [0:0]         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [1:0]         w_occ_next;

    // Readys are already gated by state, so at most one stream is accepted.
    assign w_info_acc     = s_info_tvalid & r_info_ready;
    assign w_par_acc      = s_par_tvalid & r_par_ready;
    assign w_push         = w_info_acc | w_par_acc;
    assign w_pop          = r_m_valid & m_axis_tready;
    assign w_par_cnt_last = (r_cnt == c_PAR_LAST);
    assign w_cnt_last     = (r_state == S_INFO) ? (r_cnt == c_INFO_LAST) : w_par_cnt_last;
    assign w_in_data      = w_par_acc ? s_par_tdata : s_info_tdata;
    // Codeword end comes from the beat counter alone; s_par_tlast is only audited.
    assign w_in_last      = w_par_acc & w_par_cnt_last;

    // Next-state, counter and occupancy decode shared by the registered readys.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_occ_next   = r_occ;
        if (w_push) begin
            if (w_cnt_last) begin
                w_state_next = ~r_state;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next   = r_cnt + 1'b1;
            end
        end
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + 2'd1;
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - 2'd1;
        end
    end

    // FSM, beat counter and readys; readys look one cycle ahead so they stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_INFO;
            r_cnt        <= '0;
            r_info_ready <= 1'b0;
            r_par_ready  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_info_ready <= (w_state_next == S_INFO) && (w_occ_next != 2'd2);
            r_par_ready  <= (w_state_next == S_PAR)  && (w_occ_next != 2'd2);
        end
    end

    // Two-entry skid buffer; a push and pop in the same cycle keeps occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ       <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            r_occ     <= w_occ_next;
            r_m_valid <= (w_occ_next != 2'd0);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= w_in_data;
                        r_head_last <= w_in_last;
                    end else begin
                        r_skid_data <= w_in_data;
                        r_skid_last <= w_in_last;
                    end
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_skid_data;
                        r_head_last <= r_skid_last;
                    end
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_skid_data;
                        r_head_last <= r_skid_last;
                        r_skid_data <= w_in_data;
                        r_skid_last <= w_in_last;
                    end else begin
                        r_head_data <= w_in_data;
                        r_head_last <= w_in_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One-cycle flag when the encoder's tlast disagrees with the counter framing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_par_acc & (s_par_tlast != w_par_cnt_last);
        end
    end

    assign s_info_tready = r_info_ready;
    assign s_par_tready  = r_par_ready;
    assign m_axis_tdata  = r_head_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_head_last;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_codeword_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldpc_codeword_assembler
//  Description : Self-checking bench for ldpc_codeword_assembler, with one
//                instance at 8-bit beats and one at 16-bit beats. Expected
//                codewords are built from the planned info and check data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_codeword_assembler;

    localparam int IB0 = 892;
    localparam int PB0 = 128;
    localparam int IB1 = 446;
    localparam int PB1 = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] info_data  [2];
    logic        info_valid [2];
    logic [15:0] par_data   [2];
    logic        par_valid  [2];
    logic        par_last   [2];
    logic        m_ready    [2];

    logic        info_rdy0, par_rdy0, m_valid0, m_last0, fe0;
    logic [7:0]  m_data0;
    logic        info_rdy1, par_rdy1, m_valid1, m_last1, fe1;
    logic [15:0] m_data1;

    ldpc_codeword_assembler #(.WIDTH(8), .INFO_BITS(7136), .PAR_BITS(1024)) u_dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_info_tdata  (info_data[0][7:0]),
        .s_info_tvalid (info_valid[0]),
        .s_info_tready (info_rdy0),
        .s_par_tdata   (par_data[0][7:0]),
        .s_par_tvalid  (par_valid[0]),
        .s_par_tlast   (par_last[0]),
        .s_par_tready  (par_rdy0),
        .m_axis_tdata  (m_data0),
        .m_axis_tvalid (m_valid0),
        .m_axis_tlast  (m_last0),
        .m_axis_tready (m_ready[0]),
        .frame_err     (fe0)
    );

    ldpc_codeword_assembler #(.WIDTH(16), .INFO_BITS(7136), .PAR_BITS(1024)) u_dut16 (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_info_tdata  (info_data[1]),
        .s_info_tvalid (info_valid[1]),
        .s_info_tready (info_rdy1),
        .s_par_tdata   (par_data[1]),
        .s_par_tvalid  (par_valid[1]),
        .s_par_tlast   (par_last[1]),
        .s_par_tready  (par_rdy1),
        .m_axis_tdata  (m_data1),
        .m_axis_tvalid (m_valid1),
        .m_axis_tlast  (m_last1),
        .m_axis_tready (m_ready[1]),
        .frame_err     (fe1)
    );

    // Reference model state: pending input beats and expected codeword beats.
    logic [15:0] info_q [2][$];
    logic [17:0] par_q  [2][$];   // {tlast mismatch, tlast driven, data}
    logic [16:0] exp_q  [2][$];   // {tlast, data}
    int          tl_idx [2][$];
    int out_cnt[2], fe_cnt[2], first_cyc[2], last_cyc[2], first_acc[2];
    int info_acc[2], par_acc[2];
    bit mon_en[2];
    logic pv[2], pr[2], pl[2];
    logic [15:0] pd[2];

    int n_pass = 0;
    int n_checks = 0;

    function automatic int ib(input int d); return (d == 0) ? IB0 : IB1; endfunction
    function automatic int pb(input int d); return (d == 0) ? PB0 : PB1; endfunction
    function automatic logic info_ready(input int d); return (d == 0) ? info_rdy0 : info_rdy1; endfunction
    function automatic logic par_ready(input int d); return (d == 0) ? par_rdy0 : par_rdy1; endfunction
    function automatic logic m_valid(input int d); return (d == 0) ? m_valid0 : m_valid1; endfunction
    function automatic logic m_last(input int d); return (d == 0) ? m_last0 : m_last1; endfunction
    function automatic logic fe(input int d); return (d == 0) ? fe0 : fe1; endfunction
    function automatic logic [15:0] m_data(input int d);
        return (d == 0) ? {8'h00, m_data0} : m_data1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic clear_stats(input int d);
        out_cnt[d] = 0; fe_cnt[d] = 0; first_cyc[d] = 0; last_cyc[d] = 0;
        first_acc[d] = 0; info_acc[d] = 0; par_acc[d] = 0;
        tl_idx[d].delete();
    endtask

    // Plan one codeword: info beats then check beats, tlast on the final check beat.
    task automatic plan(input int d, input bit rnd_data, input bit bad_tlast);
        logic [15:0] v;
        logic tl, lst;
        for (int i = 0; i < ib(d); i++) begin
            if (rnd_data)    v = 16'($urandom);
            else if (d == 0) v = 16'(i % 124);
            else             v = {8'((2 * i) % 124), 8'((2 * i + 1) % 124)};
            if (d == 0) v[15:8] = 8'h00;
            info_q[d].push_back(v);
            exp_q[d].push_back({1'b0, v});
        end
        for (int j = 0; j < pb(d); j++) begin
            if (rnd_data)    v = 16'($urandom);
            else if (d == 0) v = {8'h00, 8'hA5 ^ 8'(j)};
            else             v = {8'hA5 ^ 8'(2 * j), 8'hA5 ^ 8'(2 * j + 1)};
            if (d == 0) v[15:8] = 8'h00;
            lst = (j == pb(d) - 1);
            tl  = bad_tlast ? (j == 100) : lst;
            par_q[d].push_back({tl != lst, tl, v});
            exp_q[d].push_back({lst, v});
        end
    endtask

    task automatic drive_info(input int d, input bit rnd);
        int budget = 0;
        bit acc;
        while (info_q[d].size() > 0 && budget < 40000) begin
            if (info_valid[d] || !rnd || $urandom_range(0, 1) == 1) begin
                info_valid[d] = 1'b1;
                info_data[d]  = info_q[d][0];
            end
            acc = info_valid[d] && info_ready(d);
            @(posedge clk); #1; budget++;
            if (acc) begin
                void'(info_q[d].pop_front());
                info_valid[d] = 1'b0;
            end
        end
        info_valid[d] = 1'b0;
        chk("info_all_sent", info_q[d].size(), 0);
    endtask

    task automatic drive_par(input int d, input bit rnd);
        int budget = 0;
        bit acc;
        logic [17:0] e;
        while (par_q[d].size() > 0 && budget < 40000) begin
            e = par_q[d][0];
            if (par_valid[d] || !rnd || $urandom_range(0, 1) == 1) begin
                par_valid[d] = 1'b1;
                par_data[d]  = e[15:0];
                par_last[d]  = e[16];
            end
            acc = par_valid[d] && par_ready(d);
            @(posedge clk); #1; budget++;
            if (acc) begin
                void'(par_q[d].pop_front());
                chk("frame_err_pulse", fe(d), e[17]);
                par_valid[d] = 1'b0;
            end
        end
        par_valid[d] = 1'b0;
        par_last[d]  = 1'b0;
        chk("par_all_sent", par_q[d].size(), 0);
    endtask

    task automatic rand_ready(input int d);
        int budget = 0;
        while (exp_q[d].size() > 0 && budget < 40000) begin
            m_ready[d] = 1'($urandom_range(0, 1));
            @(posedge clk); #1; budget++;
        end
        m_ready[d] = 1'b1;
    endtask

    task automatic wait_drain(input int d);
        int budget = 0;
        while (exp_q[d].size() > 0 && budget < 2000) begin
            @(posedge clk); #1; budget++;
        end
        chk("drained", exp_q[d].size(), 0);
    endtask

    // Monitor: output scoreboard, stall stability, stream ordering, frame_err count.
    initial begin
        int ia, pa;
        logic [16:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mon_en[d]) begin
                    if (pv[d] && !pr[d]) begin
                        chk("stall_valid", m_valid(d), 1);
                        chk("stall_data", m_data(d), pd[d]);
                        chk("stall_last", m_last(d), pl[d]);
                    end
                    ia = info_acc[d];
                    pa = par_acc[d];
                    if (par_valid[d] && par_ready(d)) begin
                        if (pa % pb(d) == 0) chk("par_after_info", ia >= (pa / pb(d) + 1) * ib(d), 1);
                        par_acc[d]++;
                    end
                    if (info_valid[d] && info_ready(d)) begin
                        if (ia == 0) first_acc[d] = cyc;
                        if (ia % ib(d) == 0) chk("info_after_par", pa >= (ia / ib(d)) * pb(d), 1);
                        info_acc[d]++;
                    end
                    if (m_valid(d) && m_ready[d]) begin
                        chk("beat_expected", exp_q[d].size() > 0, 1);
                        if (exp_q[d].size() > 0) begin
                            e = exp_q[d].pop_front();
                            chk("out_data", m_data(d), e[15:0]);
                            chk("out_last", m_last(d), e[16]);
                        end
                        if (m_last(d)) tl_idx[d].push_back(out_cnt[d]);
                        if (out_cnt[d] == 0) first_cyc[d] = cyc;
                        last_cyc[d] = cyc;
                        out_cnt[d]++;
                    end
                    if (fe(d)) fe_cnt[d]++;
                end
                pv[d] = m_valid(d);
                pr[d] = m_ready[d];
                pd[d] = m_data(d);
                pl[d] = m_last(d);
            end
        end
    end

    initial begin
        int cnt;
        int budget;
        bit acc;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            info_valid[d] = 1'b0; par_valid[d] = 1'b0; par_last[d] = 1'b0;
            info_data[d] = '0; par_data[d] = '0; m_ready[d] = 1'b1;
            mon_en[d] = 1'b0; pv[d] = 1'b0; pr[d] = 1'b1; pd[d] = '0; pl[d] = 1'b0;
            clear_stats(d);
        end
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_m_valid", m_valid(d), 0);
            chk("rst_m_last", m_last(d), 0);
            chk("rst_m_data", m_data(d), 0);
            chk("rst_info_ready", info_ready(d), 0);
            chk("rst_par_ready", par_ready(d), 0);
            chk("rst_frame_err", fe(d), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("info_ready_after_rst", info_ready(d), 1);
            chk("par_ready_after_rst", par_ready(d), 0);
            mon_en[d] = 1'b1;
        end

        // Pattern data, full throughput, both widths; check beats offered from the start
        plan(0, 1'b0, 1'b0);
        plan(1, 1'b0, 1'b0);
        fork
            drive_info(0, 1'b0);
            drive_par(0, 1'b0);
            drive_info(1, 1'b0);
            drive_par(1, 1'b0);
        join
        wait_drain(0);
        wait_drain(1);
        chk("w8_beats", out_cnt[0], 1020);
        chk("w8_span", last_cyc[0] - first_cyc[0] + 1, 1020);
        chk("w8_tlast_count", tl_idx[0].size(), 1);
        chk("w8_tlast_pos", (tl_idx[0].size() > 0) ? tl_idx[0][0] : -1, 1019);
        chk("w8_latency", (first_cyc[0] - first_acc[0]) >= 1, 1);
        chk("w8_frame_err", fe_cnt[0], 0);
        chk("w16_beats", out_cnt[1], 510);
        chk("w16_span", last_cyc[1] - first_cyc[1] + 1, 510);
        chk("w16_tlast_count", tl_idx[1].size(), 1);
        chk("w16_tlast_pos", (tl_idx[1].size() > 0) ? tl_idx[1][0] : -1, 509);
        chk("w16_frame_err", fe_cnt[1], 0);

        // Random data, valids and backpressure over three back-to-back codewords;
        // the middle one has encoder tlast on check beat 100 instead of 127
        clear_stats(0);
        plan(0, 1'b1, 1'b0);
        plan(0, 1'b1, 1'b1);
        plan(0, 1'b1, 1'b0);
        fork
            drive_info(0, 1'b1);
            drive_par(0, 1'b1);
            rand_ready(0);
        join
        wait_drain(0);
        chk("rnd_beats", out_cnt[0], 3060);
        chk("rnd_tlast_count", tl_idx[0].size(), 3);
        for (int k = 0; k < 3; k++)
            chk("rnd_tlast_pos", (tl_idx[0].size() > k) ? tl_idx[0][k] : -1, 1019 + 1020 * k);
        chk("rnd_frame_err_count", fe_cnt[0], 2);

        // Reset after info beat 500, then a full codeword
        mon_en[0] = 1'b0;
        m_ready[0] = 1'b1;
        cnt = 0;
        budget = 0;
        while (cnt < 501 && budget < 2000) begin
            info_valid[0] = 1'b1;
            info_data[0]  = 16'(cnt % 124);
            acc = info_ready(0);
            @(posedge clk); #1; budget++;
            if (acc) cnt++;
        end
        chk("pre_reset_accepted", cnt, 501);
        rst_n = 1'b0;
        info_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_m_valid", m_valid(0), 0);
        chk("mid_rst_m_last", m_last(0), 0);
        chk("mid_rst_m_data", m_data(0), 0);
        chk("mid_rst_info_ready", info_ready(0), 0);
        chk("mid_rst_par_ready", par_ready(0), 0);
        chk("mid_rst_frame_err", fe(0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_info_ready_up", info_ready(0), 1);
        clear_stats(0);
        mon_en[0] = 1'b1;
        plan(0, 1'b0, 1'b0);
        fork
            drive_info(0, 1'b0);
            drive_par(0, 1'b0);
        join
        wait_drain(0);
        chk("post_rst_beats", out_cnt[0], 1020);
        chk("post_rst_tlast_count", tl_idx[0].size(), 1);
        chk("post_rst_tlast_pos", (tl_idx[0].size() > 0) ? tl_idx[0][0] : -1, 1019);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
